// File: rtl/state_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | state_ctrl: multi-cycle FETCH/EXEC1/EXEC2 sequencer with memory and        |
// | mul/div stalls. Optional define WAITREQ_TIMEOUT_EN adds a waitrequest      |
// | timeout that halts the core and raises a sticky error.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

typedef logic [5:0]  opcode_t;
typedef logic [5:0]  funct_t;
typedef logic [4:0]  regaddr_t;
typedef logic [31:0] size_t;
typedef enum logic [2:0] {
  IDLE   = 3'd0,
  FETCH  = 3'd1,
  EXEC1  = 3'd2,
  EXEC2  = 3'd3,
  HALTED = 3'd4
} state_t;

module state_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic     clk,
  input  logic     reset_i,
  input  opcode_t  opcode_i,
  input  funct_t   funct_i,
  input  regaddr_t rt_i,
  input  size_t    pc_i,
  input  logic     waitrequest_i,
  input  logic     md_busy_i,
  output state_t   state_o,
  output logic     ir_wen_o,
  output logic     pc_wen_o,
  output logic     reg_wen_o,
  output logic     mem_read_o,
  output logic     mem_write_o,
  output logic     addr_sel_o,
  output logic     active_o,
  output logic     error_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_chk
    $error("state_ctrl: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t state_q, state_d;
  logic   w_is_load, w_is_store, w_is_mem, w_is_special, w_is_mfhilo, w_is_write;
  logic   w_timeout;

  always_comb begin
    w_is_special = (opcode_i == 6'h00);
    w_is_load    = opcode_i inside {[6'h20:6'h26]};
    w_is_store   = opcode_i inside {6'h28, 6'h29, 6'h2B};
    w_is_mem     = w_is_load | w_is_store;
    w_is_mfhilo  = w_is_special && (funct_i inside {6'h10, 6'h12});
    // JR, MTHI/MTLO and MULT/DIV class produce no GPR result.
    w_is_write   = (w_is_special && !(funct_i inside {6'h08, 6'h11, 6'h13, [6'h18:6'h1B]}))
                 || (opcode_i == 6'h03)
                 || ((opcode_i == 6'h01) && (rt_i inside {5'h10, 5'h11}))
                 || (opcode_i inside {[6'h08:6'h0F]})
                 || w_is_load;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ir_wen_o    = 1'b0;
    pc_wen_o    = 1'b0;
    reg_wen_o   = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    addr_sel_o  = 1'b0;
    active_o    = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        active_o = 1'b1;
        if (pc_i == '0) begin
          state_d = HALTED;
        end else begin
          mem_read_o = 1'b1;
          if (!waitrequest_i) state_d = EXEC1;
        end
      end
      EXEC1: begin
        active_o = 1'b1;
        ir_wen_o = 1'b1;
        if (w_is_mem) begin
          mem_read_o  = w_is_load;
          mem_write_o = w_is_store;
          addr_sel_o  = 1'b1;
        end
        if (!(w_is_mem && waitrequest_i)) begin
          pc_wen_o = 1'b1;
          state_d  = EXEC2;
        end
      end
      EXEC2: begin
        active_o = 1'b1;
        if (!(w_is_mfhilo && md_busy_i)) begin
          reg_wen_o = w_is_write;
          state_d   = FETCH;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
    if (w_timeout) state_d = HALTED;
  end

  assign state_o = state_q;

`ifdef WAITREQ_TIMEOUT_EN
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

  logic        w_req;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        error_q, error_d;

  assign w_req = ((state_q == FETCH) && (pc_i != '0)) || ((state_q == EXEC1) && w_is_mem);

  // The request is still presented during the final stalled cycle; it drops in HALTED.
  always_comb begin
    tmo_cnt_d = (w_req && waitrequest_i) ? tmo_cnt_q + 16'd1 : 16'd0;
    w_timeout = w_req && waitrequest_i && (tmo_cnt_q == c_timeout_last);
    error_d   = error_q | w_timeout;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      tmo_cnt_q <= 16'd0;
      error_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      error_q   <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign w_timeout = 1'b0;
  assign error_o   = 1'b0;
`endif

endmodule

`default_nettype wire
